// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with a small byte FIFO and sticky error flags.
// Line is synchronized, sampled mid-bit, and drained over valid/ready.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       urx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic       clr_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] C_HALF =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_FULL =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] C_DEPTH =
    (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic          r_meta;
  logic          r_rx_s;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_ferr;
  logic          r_ovr;

  logic w_tick;
  logic w_stop;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_drop;
  logic w_wr;

  assign w_tick = (r_cnt == '0);
  assign w_stop = (r_state == S_STOP) && w_tick;
  assign w_push = w_stop && r_rx_s;
  assign w_pop  = rx_valid && rx_ready;
  assign w_full = (r_count == C_DEPTH);
  assign w_drop = w_push && w_full && !w_pop;
  assign w_wr   = w_push && !w_drop;

  assign rx_valid  = (r_count != '0);
  assign rx_data   = rx_valid ? r_mem[r_rptr] : '0;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b1;
      r_rx_s <= 1'b1;
    end else begin
      r_meta <= urx;
      r_rx_s <= r_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_cnt   <= C_HALF;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (r_rx_s) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt   <= C_FULL;
            r_bit   <= '0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_shift <= {r_rx_s, r_shift[7:1]};
            r_cnt   <= C_FULL;
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) r_state <= S_STOP;
          end
        end
        S_STOP: begin
          // leave mid stop bit so a back-to-back start edge is seen
          if (!w_tick) r_cnt <= r_cnt - 1'b1;
          else         r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= r_shift;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      unique case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_stop && !r_rx_s) r_ferr <= 1'b1;
      else if (clr_err)      r_ferr <= 1'b0;
      if (w_drop)            r_ovr  <= 1'b1;
      else if (clr_err)      r_ovr  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: frame table, directed corner sequences,
// and random traffic against a queue-based reference.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst;
  logic       urx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       clr_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(
    .CLKS_PER_BIT(16),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .urx      (urx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .clr_err  (clr_err),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       s;
    logic       ev;
    logic [7:0] ed;
    logic       efe;
  } vec_t;

  vec_t tbl [6];

  logic       wave [$];
  int         ev_at [$];
  logic [7:0] ev_b [$];
  logic       ev_s [$];
  logic [7:0] q [$];
  logic       m_fe;
  logic       m_ov;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // start bit and 8 data bits; returns with the stop level applied
  task automatic drive_frame(input logic [7:0] b,
                             input logic s);
    urx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      urx = b[i];
      repeat (16) @(negedge clk);
    end
    urx = s;
  endtask

  task automatic send(input logic [7:0] b);
    drive_frame(b, 1'b1);
    repeat (16) @(negedge clk);
  endtask

  task automatic pop_check(input logic [7:0] e);
    chk("pop_valid", 32'(rx_valid), 32'd1);
    chk("pop_data", 32'(rx_data), 32'(e));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic ref_compare();
    chk("rnd_valid", 32'(rx_valid), 32'(q.size() != 0));
    chk("rnd_data", 32'(rx_data),
        (q.size() != 0) ? 32'(q[0]) : 32'd0);
    chk("rnd_ferr", 32'(frame_err), 32'(m_fe));
    chk("rnd_ovr", 32'(overrun), 32'(m_ov));
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b0;
    urx      = 1'b1;
    rx_ready = 1'b0;
    clr_err  = 1'b0;

    tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
    tbl[1] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    tbl[4] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0};
    tbl[5] = '{8'h01, 1'b0, 1'b0, 8'h00, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      drive_frame(tbl[v].b, tbl[v].s);
      repeat (9) @(negedge clk);
      urx = 1'b1;
      @(negedge clk);
      chk("tbl_pre_valid", 32'(rx_valid), 32'd0);
      chk("tbl_pre_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("tbl_valid", 32'(rx_valid), 32'(tbl[v].ev));
      chk("tbl_data", 32'(rx_data), 32'(tbl[v].ed));
      chk("tbl_ferr", 32'(frame_err), 32'(tbl[v].efe));
      chk("tbl_busy", 32'(busy), 32'd0);
      repeat (5) @(negedge clk);
      if (tbl[v].ev) pop_check(tbl[v].ed);
      else clr_pulse();
      chk("tbl_empty", 32'(rx_valid), 32'd0);
      chk("tbl_ferr_clr", 32'(frame_err), 32'd0);
    end

    // start glitch shorter than half a bit
    urx = 1'b0;
    repeat (2) @(negedge clk);
    chk("gl_busy_early", 32'(busy), 32'd0);
    @(negedge clk);
    chk("gl_busy_on", 32'(busy), 32'd1);
    @(negedge clk);
    urx = 1'b1;
    repeat (6) @(negedge clk);
    chk("gl_busy_hold", 32'(busy), 32'd1);
    @(negedge clk);
    chk("gl_busy_off", 32'(busy), 32'd0);
    chk("gl_valid", 32'(rx_valid), 32'd0);
    chk("gl_ferr", 32'(frame_err), 32'd0);
    repeat (20) @(negedge clk);
    chk("gl_valid_late", 32'(rx_valid), 32'd0);

    // push and pop on the same cycle while full
    clr_pulse();
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    chk("pp_full_ovr", 32'(overrun), 32'd0);
    drive_frame(8'h55, 1'b1);
    repeat (10) @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("pp_ovr", 32'(overrun), 32'd0);
    repeat (5) @(negedge clk);
    pop_check(8'h22);
    pop_check(8'h33);
    pop_check(8'h44);
    pop_check(8'h55);
    chk("pp_empty", 32'(rx_valid), 32'd0);

    // overrun with back-to-back frames
    for (int i = 1; i <= 5; i++) send(8'(i));
    chk("ov_flag", 32'(overrun), 32'd1);
    chk("ov_ferr", 32'(frame_err), 32'd0);
    for (int i = 1; i <= 4; i++) pop_check(8'(i));
    chk("ov_empty", 32'(rx_valid), 32'd0);
    chk("ov_sticky", 32'(overrun), 32'd1);

    // reset in the middle of bit 3 of 0xFF
    send(8'h77);
    urx = 1'b0;
    repeat (16) @(negedge clk);
    urx = 1'b1;
    repeat (53) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mr_valid", 32'(rx_valid), 32'd0);
    chk("mr_data", 32'(rx_data), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_ovr", 32'(overrun), 32'd0);
    chk("mr_ferr", 32'(frame_err), 32'd0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("mr_idle", 32'(busy), 32'd0);
    drive_frame(8'h12, 1'b1);
    repeat (11) @(negedge clk);
    chk("mr_rx_valid", 32'(rx_valid), 32'd1);
    chk("mr_rx_data", 32'(rx_data), 32'h12);
    repeat (5) @(negedge clk);
    pop_check(8'h12);

    // random traffic against a byte-queue reference
    clr_pulse();
    for (int f = 0; f < 10; f++) begin
      int gap;
      int n0;
      logic [7:0] b;
      logic s;
      gap = $urandom_range(0, 20);
      b = 8'($urandom);
      s = ($urandom_range(0, 5) != 0);
      for (int j = 0; j < gap; j++) wave.push_back(1'b1);
      n0 = wave.size();
      for (int j = 0; j < 16; j++) wave.push_back(1'b0);
      for (int k = 0; k < 8; k++)
        for (int j = 0; j < 16; j++) wave.push_back(b[k]);
      if (s) begin
        for (int j = 0; j < 16; j++) wave.push_back(1'b1);
      end else begin
        for (int j = 0; j < 9; j++) wave.push_back(1'b0);
        for (int j = 0; j < 7; j++) wave.push_back(1'b1);
      end
      ev_at.push_back(n0 + 154);
      ev_b.push_back(b);
      ev_s.push_back(s);
    end
    for (int j = 0; j < 20; j++) wave.push_back(1'b1);

    m_fe = 1'b0;
    m_ov = 1'b0;
    begin
      int ei;
      ei = 0;
      for (int c = 0; c < wave.size(); c++) begin
        int sz;
        logic pop;
        logic ev;
        logic fe_set;
        logic ov_set;
        ref_compare();
        urx      = wave[c];
        rx_ready = ($urandom_range(0, 7) == 0);
        clr_err  = ($urandom_range(0, 31) == 0);
        sz     = q.size();
        pop    = rx_ready && (sz > 0);
        ev     = (ei < ev_at.size()) && (ev_at[ei] == c);
        fe_set = 1'b0;
        ov_set = 1'b0;
        if (pop) void'(q.pop_front());
        if (ev) begin
          if (!ev_s[ei]) fe_set = 1'b1;
          else if (sz < 4 || pop) q.push_back(ev_b[ei]);
          else ov_set = 1'b1;
          ei++;
        end
        m_fe = fe_set ? 1'b1 : (clr_err ? 1'b0 : m_fe);
        m_ov = ov_set ? 1'b1 : (clr_err ? 1'b0 : m_ov);
        @(negedge clk);
      end
      rx_ready = 1'b0;
      clr_err  = 1'b0;
      ref_compare();
      chk("rnd_events", 32'(ei), 32'(ev_at.size()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front end of the `risc_v` SoC. It takes the asynchronous `urx` pin, recovers 8N1 frames at a fixed bit period, and buffers the received bytes in a small FIFO. The core's memory-mapped UART register drains the FIFO over a valid/ready interface. The block sits directly upstream of the core's UART read path and reports framing and overrun errors as sticky status bits.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200). Legal values are ≥ 4.
- `FIFO_DEPTH`, default 4: number of byte entries. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low. Asserted (0) clears all state immediately.
- `urx`  in  1  serial line, idle high, asynchronous to `clk`.
- `rx_data`  out  8  byte at the FIFO head. Reads 0 when the FIFO is empty.
- `rx_valid`  out  1  FIFO is non-empty.
- `rx_ready`  in  1  consumer accepts `rx_data`. A pop occurs when `rx_valid && rx_ready`.
- `clr_err`  in  1  one-cycle pulse that clears `frame_err` and `overrun`.
- `frame_err`  out  1  sticky: a frame was received with stop bit = 0.
- `overrun`  out  1  sticky: a byte was dropped because the FIFO was full.
- `busy`  out  1  receiver FSM is not in IDLE.

## Operation
- **Synchronizer:** 2-flop chain on `urx`, reset to 1. Its output is `rx_s`. All FSM decisions use `rx_s`.
- **Counter:** the bit counter is $clog2(`CLKS_PER_BIT`) wide. HALF = `CLKS_PER_BIT`/2, floor.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: on `rx_s`==0, load the counter with HALF-1 and go to START.
  - START: count down to 0, then sample `rx_s`.
    - Sample is 1 (glitch): return to IDLE and push nothing.
    - Sample is 0: reload the counter with `CLKS_PER_BIT`-1, clear the bit index, go to DATA.
  - DATA: when the counter reaches 0, shift `rx_s` into the shift register LSB-first and reload the counter. After bit index 7, go to STOP.
  - STOP: when the counter reaches 0, sample `rx_s`.
    - Sample is 1: push the shift-register byte into the FIFO.
    - Sample is 0: set `frame_err` and drop the byte.
    - In both cases return to IDLE in the same cycle, i.e. mid stop bit. This allows back-to-back frames.
- **FIFO:** circular buffer with read/write pointers and a count of width $clog2(`FIFO_DEPTH`)+1.
  - `rx_data` is read combinationally from the head entry.
  - Push when full with no pop in the same cycle: the byte is dropped and `overrun` is set.
  - Push and pop in the same cycle: both take effect, the count is unchanged, and there is no overrun even when full.
  - Pop while empty: ignored.
- **Sticky flags:** set has priority over `clr_err` in the same cycle.
- **Reset:** FSM to IDLE, pointers/count to 0, storage to 0, flags to 0, synchronizer to 1. Reset during a frame discards the partial byte. The FSM resumes only on a fresh falling edge after release; a line still low at release is treated as a start bit.

## Timing
- **Reset values:** `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0.
- **Synchronizer latency:** `rx_s` lags `urx` by 2 cycles.
- **Sample points:** let D be the first cycle IDLE sees `rx_s`=0. `busy`=1 from D+1.
  - Start sample: D+HALF.
  - Data bit i: D+HALF+(i+1)·`CLKS_PER_BIT`.
  - Stop: D+HALF+9·`CLKS_PER_BIT`.
- **Output timing after the stop sample:** `rx_valid` and the flags update on the cycle after the stop sample. `busy`=0 on that same cycle.
- **Pop timing:** the pop is visible the cycle after the handshake. A new head appears on `rx_data`, or `rx_valid` drops.
- **Throughput:** one byte per 10·`CLKS_PER_BIT` cycles sustained. No backpressure to the line; excess bytes produce overrun.

## Test plan
Directed scenarios, with `CLKS_PER_BIT`=16 and `FIFO_DEPTH`=4:
- **Single byte:** send 0xA5 at 16 cycles/bit, `rx_ready`=0 → `rx_valid`=1 and `rx_data`=0xA5 one cycle after the stop sample (D+8+144). `frame_err`=0. Then pulse `rx_ready` → `rx_valid`=0 next cycle.
- **Glitch:** drive `urx` low for 4 cycles, then high → FSM returns to IDLE at D+8, `rx_valid` stays 0, no error.
- **Framing error:** send 0x3C with stop bit 0 → `frame_err`=1, FIFO empty. Pulse `clr_err` → `frame_err`=0 next cycle.
- **Overrun:** send 0x01..0x05 back-to-back with `rx_ready`=0 → 4 entries, `overrun`=1. Pops return 0x01, 0x02, 0x03, 0x04 in order; 0x05 is lost.
- **Push and pop when full:** with the FIFO full, hold `rx_ready`=1 on the push cycle of 0x55 → no overrun, count stays 4, 0x55 is read last.
- **Reset mid-frame:** assert `rst` during bit 3 of 0xFF → outputs are at reset values immediately. Then send 0x12 → 0x12 is received correctly.
